// File: rtl/instruction_set_pkg.sv
// Shared encodings for the z8 data/stack memory unit: memory operations,
// fault causes and the memory controller states.
package instruction_set;

  typedef enum logic [2:0] {
    MEM_NONE  = 3'd0,
    MEM_READ  = 3'd1,
    MEM_WRITE = 3'd2,
    MEM_PUSH  = 3'd3,
    MEM_POP   = 3'd4
  } mem_op_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_ADDR = 2'd1,
    FLT_OVF  = 2'd2,
    FLT_UNF  = 2'd3
  } fault_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Hardware stack pointer: points at the top element, DATA_DEPTH means empty.
// The stack grows downward from the top of data RAM and never wraps.
module stack_pointer_unit #(
  parameter int ADDR_W      = 16,
  parameter int DATA_DEPTH  = 256,
  parameter int STACK_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic              ovf,
  output logic              unf
);

  localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(DATA_DEPTH);
  localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(DATA_DEPTH - STACK_DEPTH);

  assign ovf = (sp == SP_FULL);
  assign unf = (sp == SP_EMPTY);

  // Fault cases are blocked here as well so sp can never leave its legal range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= SP_EMPTY;
    end else if (push && !ovf) begin
      sp <= sp - ADDR_W'(1);
    end else if (pop && !unf) begin
      sp <= sp + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/data_stack_memory_unit.sv
// Program store with loader port plus data RAM holding a downward-growing hardware
// stack; the data RAM is swept to zero after reset and the first fault is sticky.
module data_stack_memory_unit
  import instruction_set::*;
#(
  parameter int DATA_W      = 16,
  parameter int DATA_DEPTH  = 256,
  parameter int INSTR_W     = 40,
  parameter int PROG_DEPTH  = 256,
  parameter int STACK_DEPTH = 64,
  parameter int ADDR_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic [INSTR_W-1:0] current_instruction,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic               ready,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [ADDR_W-1:0]  sp
);

  localparam int DIDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int PIDX_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam logic [DIDX_W-1:0] CLR_LAST = DIDX_W'(DATA_DEPTH - 1);

  logic [DATA_W-1:0]  data_mem [DATA_DEPTH];
  logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];

  mem_state_t        state, state_next;
  fault_t            fault_code_q, fault_next_code;
  logic [DIDX_W-1:0] clr_cnt;
  logic              fault_now;
  logic              mem_we;
  logic [DIDX_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              push_go, pop_go, ovf, unf;
  logic [ADDR_W-1:0] sp_dec;
  logic              addr_ok, pc_ok, prog_ok;

  assign addr_ok = (32'(addr) < 32'(DATA_DEPTH));
  assign pc_ok   = (32'(pc) < 32'(PROG_DEPTH));
  assign prog_ok = (32'(prog_addr) < 32'(PROG_DEPTH));
  assign sp_dec  = sp - ADDR_W'(1);
  assign push_go = (state == RUN) && (op == MEM_PUSH);
  assign pop_go  = (state == RUN) && (op == MEM_POP);

  stack_pointer_unit #(
    .ADDR_W      (ADDR_W),
    .DATA_DEPTH  (DATA_DEPTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_sp (
    .clk   (clk),
    .reset (reset),
    .push  (push_go),
    .pop   (pop_go),
    .sp    (sp),
    .ovf   (ovf),
    .unf   (unf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      fault_code_q <= FLT_NONE;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + DIDX_W'(1);
      if (fault_now) fault_code_q <= fault_next_code;
    end
  end

  // A faulting op raises fault_now and suppresses its own write, so it has no side effect.
  always_comb begin
    state_next      = state;
    fault_now       = 1'b0;
    fault_next_code = FLT_NONE;
    read_data       = '0;
    mem_we          = 1'b0;
    mem_waddr       = '0;
    mem_wdata       = '0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        if (clr_cnt == CLR_LAST) state_next = RUN;
      end
      RUN: begin
        case (op)
          MEM_READ: begin
            if (addr_ok) begin
              read_data = data_mem[addr[DIDX_W-1:0]];
            end else begin
              fault_now       = 1'b1;
              fault_next_code = FLT_ADDR;
            end
          end
          MEM_WRITE: begin
            if (addr_ok) begin
              mem_we    = 1'b1;
              mem_waddr = addr[DIDX_W-1:0];
              mem_wdata = write_data;
            end else begin
              fault_now       = 1'b1;
              fault_next_code = FLT_ADDR;
            end
          end
          MEM_PUSH: begin
            if (ovf) begin
              fault_now       = 1'b1;
              fault_next_code = FLT_OVF;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = sp_dec[DIDX_W-1:0];
              mem_wdata = write_data;
            end
          end
          MEM_POP: begin
            if (unf) begin
              fault_now       = 1'b1;
              fault_next_code = FLT_UNF;
            end else begin
              read_data = data_mem[sp[DIDX_W-1:0]];
            end
          end
          default: ;
        endcase
        if (fault_now) state_next = FAULT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_waddr] <= mem_wdata;
  end

  // The loader runs in every state, even during the sweep and after a fault.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) prog_mem[prog_addr[PIDX_W-1:0]] <= prog_wdata;
  end

  assign current_instruction = pc_ok ? prog_mem[pc[PIDX_W-1:0]] : '0;
  assign ready      = (state == RUN);
  assign fault      = (state == FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_data_stack_memory_unit.sv
// Self-checking bench for data_stack_memory_unit: table vectors, randomized ops
// against a behavioural memory/stack model, and hand-written reset/fault sequences.
module tb_data_stack_memory_unit;
  import instruction_set::*;

  localparam int DEPTH  = 256;
  localparam int SDEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = '0;
  logic [2:0]  op = '0;
  logic [15:0] addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic [39:0] current_instruction;
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [39:0] prog_wdata = '0;
  logic        ready;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] sp;

  data_stack_memory_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .pc                  (pc),
    .op                  (op),
    .addr                (addr),
    .write_data          (write_data),
    .read_data           (read_data),
    .current_instruction (current_instruction),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_wdata          (prog_wdata),
    .ready               (ready),
    .fault               (fault),
    .fault_code          (fault_code),
    .sp                  (sp)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents, stack pointer and run/fault status.
  logic [15:0] m_mem [DEPTH];
  int          m_sp;
  logic        m_run;
  logic        m_fault;
  logic [1:0]  m_code;

  int pass_count  = 0;
  int total_count = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic [15:0] exp_sp;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    m_sp    = DEPTH;
    m_run   = 1'b0;
    m_fault = 1'b0;
    m_code  = 2'd0;
  endtask

  task automatic modelFault(input logic [1:0] code);
    m_run   = 1'b0;
    m_fault = 1'b1;
    m_code  = code;
  endtask

  function automatic logic [15:0] modelRead(input logic [2:0] o, input logic [15:0] a);
    if (!m_run) return 16'h0;
    if (o == MEM_READ && a < DEPTH) return m_mem[a];
    if (o == MEM_POP && m_sp < DEPTH) return m_mem[m_sp];
    return 16'h0;
  endfunction

  task automatic modelUpdate(input logic [2:0] o, input logic [15:0] a, input logic [15:0] wd);
    if (m_run) begin
      case (o)
        MEM_READ:  if (a >= DEPTH) modelFault(2'd1);
        MEM_WRITE: if (a >= DEPTH) modelFault(2'd1); else m_mem[a] = wd;
        MEM_PUSH: begin
          if (m_sp == DEPTH - SDEPTH) modelFault(2'd2);
          else begin
            m_sp = m_sp - 1;
            m_mem[m_sp] = wd;
          end
        end
        MEM_POP: if (m_sp == DEPTH) modelFault(2'd3); else m_sp = m_sp + 1;
        default: ;
      endcase
    end
  endtask

  // Called at a negedge: drive, sample mid-low-phase, then advance one clock.
  task automatic applyStimulus(input logic [2:0] o, input logic [15:0] a, input logic [15:0] wd);
    op = o;
    addr = a;
    write_data = wd;
    #1;
    checkOutput("read_data", read_data, modelRead(o, a));
    checkOutput("sp", sp, 16'(m_sp));
    checkOutput("ready", ready, m_run);
    checkOutput("fault", fault, m_fault);
    checkOutput("fault_code", fault_code, m_code);
    @(posedge clk);
    modelUpdate(o, a, wd);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    op = MEM_NONE;
    prog_we = 1'b0;
    #1;
    checkOutput("rst_sp", sp, 16'(DEPTH));
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    checkOutput("rst_code", fault_code, 2'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts clock edges from reset release until ready; bounded so a stuck sweep still ends.
  task automatic waitSweep(input string tag);
    int cycles = 0;
    while (!ready && cycles < 400) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checkOutput(tag, 64'(cycles), 64'd256);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
    m_run = 1'b1;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [15:0] r_addr;

    vecs[0] = '{MEM_WRITE, 16'h0010, 16'hBEEF, 16'h0000, 16'd256, 1'b1};
    vecs[1] = '{MEM_READ,  16'h0010, 16'h0000, 16'hBEEF, 16'd256, 1'b1};
    vecs[2] = '{MEM_PUSH,  16'h0000, 16'h0011, 16'h0000, 16'd256, 1'b1};
    vecs[3] = '{MEM_PUSH,  16'h0000, 16'h0022, 16'h0000, 16'd255, 1'b1};
    vecs[4] = '{MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 16'd254, 1'b1};
    vecs[5] = '{MEM_POP,   16'h0000, 16'h0000, 16'h0022, 16'd254, 1'b1};
    vecs[6] = '{MEM_POP,   16'h0000, 16'h0000, 16'h0011, 16'd255, 1'b1};
    vecs[7] = '{MEM_NONE,  16'h0000, 16'h0000, 16'h0000, 16'd256, 1'b1};
    vecs[8] = '{MEM_READ,  16'h00FF, 16'h0000, 16'h0011, 16'd256, 1'b1};
    vecs[9] = '{MEM_READ,  16'h0010, 16'h0000, 16'hBEEF, 16'd256, 1'b1};

    @(negedge clk);
    doReset();
    waitSweep("sweep_len");
    for (int i = 0; i < DEPTH; i++) applyStimulus(MEM_READ, 16'(i), 16'h0);

    // Loader: same-cycle fetch sees the old word, the new one appears next cycle.
    pc = 16'd3;
    prog_we = 1'b1;
    prog_addr = 16'd3;
    prog_wdata = 40'hAA_0000_0001;
    @(posedge clk);
    @(negedge clk);
    prog_wdata = 40'h01_2345_6789;
    #1;
    checkOutput("fetch_old", current_instruction, 40'hAA_0000_0001);
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    #1;
    checkOutput("fetch_new", current_instruction, 40'h01_2345_6789);
    pc = 16'd300;
    #1;
    checkOutput("fetch_oob", current_instruction, 40'h0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      op = vecs[i].op;
      addr = vecs[i].addr;
      write_data = vecs[i].wd;
      #1;
      checkOutput($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_sp", i), sp, vecs[i].exp_sp);
      checkOutput($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      @(posedge clk);
      modelUpdate(vecs[i].op, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
    end

    for (int i = 0; i < 400; i++) begin
      r_op = 3'($urandom_range(0, 7));
      if (r_op == MEM_PUSH && m_sp == DEPTH - SDEPTH) r_op = MEM_POP;
      if (r_op == MEM_POP && m_sp == DEPTH) r_op = MEM_PUSH;
      r_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(DEPTH - SDEPTH, DEPTH - 1))
                                           : 16'($urandom_range(0, DEPTH - 1));
      applyStimulus(r_op, r_addr, 16'($urandom));
    end

    // Address fault is terminal: later ops are ignored, fetch still works.
    applyStimulus(MEM_WRITE, 16'd256, 16'h1234);
    checkOutput("addr_fault", fault, 1'b1);
    checkOutput("addr_code", fault_code, 2'd1);
    checkOutput("addr_ready", ready, 1'b0);
    applyStimulus(MEM_READ, 16'h0010, 16'h0);
    applyStimulus(MEM_PUSH, 16'h0, 16'h7777);
    pc = 16'd3;
    #1;
    checkOutput("fetch_in_fault", current_instruction, 40'h01_2345_6789);
    @(negedge clk);

    doReset();
    waitSweep("sweep_len2");
    for (int i = 0; i < SDEPTH; i++) applyStimulus(MEM_PUSH, 16'h0, 16'(i + 1));
    checkOutput("sp_full", sp, 16'd192);
    applyStimulus(MEM_PUSH, 16'h0, 16'hDEAD);
    checkOutput("ovf_code", fault_code, 2'd2);
    checkOutput("ovf_sp", sp, 16'd192);

    doReset();
    waitSweep("sweep_len3");
    applyStimulus(MEM_POP, 16'h0, 16'h0);
    checkOutput("unf_code", fault_code, 2'd3);
    checkOutput("unf_rd", read_data, 16'h0);

    // Reset in the middle of the sweep restarts it from the beginning.
    doReset();
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_clear_ready", ready, 1'b0);
    doReset();
    waitSweep("sweep_restart");

    // Reset while a push is presented aborts it.
    applyStimulus(MEM_PUSH, 16'h0, 16'h5555);
    op = MEM_PUSH;
    write_data = 16'hAAAA;
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_push_sp", sp, 16'd256);
    checkOutput("mid_push_fault", fault, 1'b0);
    checkOutput("mid_push_ready", ready, 1'b0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    op = MEM_NONE;
    waitSweep("sweep_after_push");
    applyStimulus(MEM_READ, 16'h00FF, 16'h0);
    applyStimulus(MEM_READ, 16'h00FE, 16'h0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
